// File: rtl/window_gen_3x3.sv
// window_gen_3x3: turns a raster-order signed pixel stream into 3x3 sliding
// windows (stride 1, no padding) for the 3x3 PE array.
// Two line buffers hold rows r-1 and r-2; a 3x3 shift register forms the window.
// A window is emitted for every accepted pixel at row>=2, col>=2.
// Note: rst_n is a synchronous, active-HIGH reset (1 = reset) despite its name.
module window_gen_3x3 #(
  parameter int input_width = 8,
  parameter int IMG_W       = 32,
  parameter int IMG_H       = 32,
  parameter int PE_arr_size = 9
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pix_valid,
  input  logic signed [input_width-1:0] pix_data,
  output logic                          pix_ready,
  output logic                          win_valid,
  output logic signed [input_width-1:0] win_data [PE_arr_size-1:0],
  input  logic                          win_ready,
  output logic                          frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(2);
  localparam logic [RW-1:0] ROW_WIN  = RW'(2);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic signed [input_width-1:0] lb1 [IMG_W];
  logic signed [input_width-1:0] lb2 [IMG_W];

  logic accept;
  logic at_window;
  logic last_pix;

  // Single output register: a new pixel may enter whenever the window slot is
  // empty or is being drained this cycle; never during reset.
  assign pix_ready = !rst_n && (!win_valid || win_ready);
  assign accept    = pix_valid && pix_ready;
  assign at_window = (row >= ROW_WIN) && (col >= COL_WIN);
  assign last_pix  = (row == ROW_LAST) && (col == COL_LAST);

  // Raster position counters; row wraps so the next frame starts at (0,0).
  always_ff @(posedge clk) begin
    if (rst_n) begin
      col <= {CW{1'b0}};
      row <= {RW{1'b0}};
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= {CW{1'b0}};
        if (row == ROW_LAST) begin
          row <= {RW{1'b0}};
        end else begin
          row <= row + RW'(1);
        end
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Line buffers: lb1 holds the previous row, lb2 the row before it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb1[i] <= {input_width{1'b0}};
        lb2[i] <= {input_width{1'b0}};
      end
    end else if (accept) begin
      lb2[col] <= lb1[col];
      lb1[col] <= pix_data;
    end
  end

  // Window shift register: shift left one column, new column enters on the
  // right (top = row r-2, middle = row r-1, bottom = incoming pixel).
  // It only moves on accept, so it stays stable while a window is stalled.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < PE_arr_size; i++) begin
        win_data[i] <= {input_width{1'b0}};
      end
    end else if (accept) begin
      for (int i = 0; i < 3; i++) begin
        win_data[3*i]     <= win_data[3*i + 1];
        win_data[3*i + 1] <= win_data[3*i + 2];
      end
      win_data[2] <= lb2[col];
      win_data[5] <= lb1[col];
      win_data[8] <= pix_data;
    end
  end

  // Window valid flag and end-of-frame pulse, both one cycle after the accept.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && last_pix;
      if (accept && at_window) begin
        win_valid <= 1'b1;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3: a 4x4 instance for the directed
// tests and a default 32x32 instance for the full-frame random test.
// The reference model keeps a full image copy and builds windows from it.
module tb_window_gen_3x3;

  typedef logic [71:0] win_t;

  logic clk = 1'b0;
  logic rst_s, rst_d, pv, wr, sel;
  logic signed [7:0] pd;

  logic pr_s, wv_s, fd_s, pr_d, wv_d, fd_d;
  logic signed [7:0] wd_s [8:0];
  logic signed [7:0] wd_d [8:0];

  logic pr_m, wv_m_dut, fd_m_dut;
  logic signed [7:0] wd_m [8:0];

  always #5 clk = ~clk;

  window_gen_3x3 #(.input_width(8), .IMG_W(4), .IMG_H(4), .PE_arr_size(9)) dut_s (
    .clk(clk), .rst_n(rst_s), .pix_valid(pv), .pix_data(pd), .pix_ready(pr_s),
    .win_valid(wv_s), .win_data(wd_s), .win_ready(wr), .frame_done(fd_s));

  window_gen_3x3 dut_d (
    .clk(clk), .rst_n(rst_d), .pix_valid(pv), .pix_data(pd), .pix_ready(pr_d),
    .win_valid(wv_d), .win_data(wd_d), .win_ready(wr), .frame_done(fd_d));

  // Route the outputs of the instance under test to the checker.
  always_comb begin
    pr_m     = sel ? pr_d : pr_s;
    wv_m_dut = sel ? wv_d : wv_s;
    fd_m_dut = sel ? fd_d : fd_s;
    for (int k = 0; k < 9; k++) wd_m[k] = sel ? wd_d[k] : wd_s[k];
  end

  int n_checks = 0, n_errors = 0;
  int img [32][32];
  int mw, mh, mr, mc;
  logic wv_exp, fd_exp, acc, rst_prev, held_flag;
  win_t held_w;
  win_t exp_q[$];
  win_t got_q[$];
  int n_win, n_fd, mode, stall_cnt;

  int t1 [4][9] = '{'{0,1,2,4,5,6,8,9,10}, '{1,2,3,5,6,7,9,10,11},
                    '{4,5,6,8,9,10,12,13,14}, '{5,6,7,9,10,11,13,14,15}};
  int t3 [9] = '{100,101,102,104,105,106,108,109,110};

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cmp_win(input string tag, input win_t o, input win_t e);
    for (int k = 0; k < 9; k++)
      check(tag, int'($signed(o[8*k +: 8])), int'($signed(e[8*k +: 8])));
  endtask

  function automatic win_t obs_win();
    win_t w;
    for (int k = 0; k < 9; k++) w[8*k +: 8] = wd_m[k];
    return w;
  endfunction

  function automatic win_t const_win(input int v [9]);
    win_t w;
    for (int k = 0; k < 9; k++) w[8*k +: 8] = 8'(v[k]);
    return w;
  endfunction

  task automatic model_reset();
    mr = 0; mc = 0; wv_exp = 1'b0; fd_exp = 1'b0; held_flag = 1'b0;
    exp_q.delete();
  endtask

  // One clock cycle: entered just after a negedge with inputs set, samples
  // mid-cycle, updates the model, and returns after the next negedge.
  task automatic tick();
    logic rst_cur, new_win, fd_next;
    win_t w;
    rst_cur = sel ? rst_d : rst_s;
    if (mode == 1) begin
      if (wv_exp && n_win == 1 && stall_cnt < 3) begin
        wr = 1'b0; stall_cnt++;
      end else wr = 1'b1;
    end else if (mode == 2) wr = ($urandom_range(0, 3) != 0);
    else wr = 1'b1;
    #2;
    acc = 1'b0;
    if (rst_cur) begin
      check("rst_pix_ready", int'(pr_m), 0);
      if (rst_prev) begin
        check("rst_win_valid", int'(wv_m_dut), 0);
        check("rst_frame_done", int'(fd_m_dut), 0);
        cmp_win("rst_win_data", obs_win(), 72'd0);
      end
      model_reset();
    end else begin
      check("pix_ready", int'(pr_m), int'(!wv_exp || wr));
      check("win_valid", int'(wv_m_dut), int'(wv_exp));
      check("frame_done", int'(fd_m_dut), int'(fd_exp));
      if (fd_m_dut) n_fd++;
      if (held_flag) cmp_win("stall_hold", obs_win(), held_w);
      if (wv_m_dut && wr) begin
        if (exp_q.size() == 0) check("unexpected_window", 1, 0);
        else begin
          w = exp_q.pop_front();
          cmp_win("win_elem", obs_win(), w);
        end
        got_q.push_back(obs_win());
        n_win++;
      end
      held_flag = wv_m_dut && !wr;
      held_w = obs_win();
      acc = pv && pr_m;
      new_win = 1'b0; fd_next = 1'b0;
      if (acc) begin
        img[mr][mc] = int'(pd);
        if (mr >= 2 && mc >= 2) begin
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              w[8*(3*i+j) +: 8] = 8'(img[mr-2+i][mc-2+j]);
          exp_q.push_back(w);
          new_win = 1'b1;
        end
        fd_next = (mr == mh-1) && (mc == mw-1);
        if (mc == mw-1) begin
          mc = 0;
          mr = (mr == mh-1) ? 0 : mr + 1;
        end else mc++;
      end
      wv_exp = new_win ? 1'b1 : (wr ? 1'b0 : wv_exp);
      fd_exp = fd_next;
    end
    rst_prev = rst_cur;
    @(negedge clk);
  endtask

  task automatic send(input int v, input bit gaps);
    int b;
    if (gaps) begin
      pv = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    pd = 8'(v); pv = 1'b1; b = 0;
    do begin tick(); b++; end while (!acc && b < 100);
    if (!acc) check("accept_timeout", 0, 1);
    pv = 1'b0;
  endtask

  // kind 0: base+k, kind 1: alternating -128/127, kind 2: random
  task automatic send_frame(input int base, input int kind, input bit gaps, input int n);
    int v;
    for (int k = 0; k < n; k++) begin
      if (kind == 0) v = base + k;
      else if (kind == 1) v = (k % 2 == 0) ? -128 : 127;
      else v = int'($signed(8'($urandom)));
      send(v, gaps);
    end
  endtask

  task automatic drain();
    int b = 0;
    pv = 1'b0;
    while ((wv_exp || exp_q.size() != 0) && b < 300) begin tick(); b++; end
    check("drain_empty", exp_q.size(), 0);
    tick(); tick();
  endtask

  task automatic start_test(input int m);
    mode = m; stall_cnt = 0; n_win = 0; n_fd = 0; got_q.delete();
  endtask

  task automatic check_t1(input string tag);
    check({tag, "_nwin"}, n_win, 4);
    check({tag, "_nfd"}, n_fd, 1);
    for (int w = 0; w < 4 && w < got_q.size(); w++)
      cmp_win(tag, got_q[w], const_win(t1[w]));
  endtask

  initial begin
    sel = 1'b0; rst_s = 1'b1; rst_d = 1'b1; pv = 1'b0; pd = 8'sd0; wr = 1'b1;
    mw = 4; mh = 4; rst_prev = 1'b0; mode = 0;
    model_reset();
    @(negedge clk);
    tick(); tick(); tick();
    rst_s = 1'b0;

    // 1: plain stream
    start_test(0);
    send_frame(0, 0, 1'b0, 16); drain();
    check_t1("t1");

    // 2: stall on second window
    start_test(1);
    send_frame(0, 0, 1'b0, 16); drain();
    check("t2_stall_cycles", stall_cnt, 3);
    check_t1("t2");

    // 3: two frames back-to-back
    start_test(0);
    send_frame(0, 0, 1'b0, 16); send_frame(100, 0, 1'b0, 16); drain();
    check("t3_nwin", n_win, 8);
    check("t3_nfd", n_fd, 2);
    if (got_q.size() > 4) cmp_win("t3_win5", got_q[4], const_win(t3));
    else check("t3_win5_missing", got_q.size(), 5);

    // 4: reset mid-frame after pixel 9
    start_test(0);
    send_frame(0, 0, 1'b0, 10);
    rst_s = 1'b1; tick(); tick(); tick();
    rst_s = 1'b0;
    start_test(0);
    send_frame(0, 0, 1'b0, 16); drain();
    check_t1("t4");

    // 5: extreme values, input gaps, random ready
    start_test(2);
    send_frame(0, 1, 1'b1, 16); drain();
    check("t5_nwin", n_win, 4);
    if (got_q.size() > 0) begin
      check("t5_e0", int'($signed(got_q[0][7:0])), -128);
      check("t5_e1", int'($signed(got_q[0][15:8])), 127);
    end else check("t5_missing", got_q.size(), 1);

    // 6: default 32x32 instance, random data and ready
    rst_s = 1'b1; sel = 1'b1; mw = 32; mh = 32;
    tick(); tick(); tick();
    rst_d = 1'b0;
    start_test(2);
    send_frame(0, 2, 1'b0, 1024); drain();
    check("t6_nwin", n_win, 900);
    check("t6_nfd", n_fd, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
